// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT stage controller and the datapath it drives.
//   - ntt_state_e : controller state encoding (IDLE/ISSUE/DRAIN/DONE, 2 bits)
//   - NttN/NttLogN/NttPipeLat : default transform length, log2 length, butterfly latency
//   - ntt_clog2  : ceiling log2 helper usable in parameter expressions
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_state_e;

  localparam int unsigned NttN       = 256;
  localparam int unsigned NttLogN    = 8;
  localparam int unsigned NttPipeLat = 4;

  function automatic int unsigned ntt_clog2(input int unsigned value);
    int unsigned res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: nested j (fastest) / group / stage counters.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            load stage-0 state (start of a transform); samples inv_i
//   advance_i          step to the next butterfly (one accepted transfer)
//   inv_i              1 = Gentleman-Sande ordering, 0 = forward ordering
//   addr_a_o/addr_b_o  upper / lower leg coefficient addresses
//   tw_idx_o           twiddle ROM index
//   stage_o            current stage number
//   last_in_stage_o    current butterfly is the final one of its stage
//   last_stage_o       current stage is LOG_N-1
module ntt_addr_gen
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned N     = NttN,
  parameter int unsigned LOG_N = NttLogN
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic             inv_i,
  output logic [LOG_N-1:0] addr_a_o,
  output logic [LOG_N-1:0] addr_b_o,
  output logic [LOG_N-1:0] tw_idx_o,
  output logic [LOG_N-1:0] stage_o,
  output logic             last_in_stage_o,
  output logic             last_stage_o
);

  localparam logic [LOG_N-1:0] OneL      = LOG_N'(1);
  localparam logic [LOG_N-1:0] HalfN     = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] AllOnes   = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] LastStage = LOG_N'(LOG_N - 1);

  logic [LOG_N-1:0] j_q, j_d;
  logic [LOG_N-1:0] g_q, g_d;
  logic [LOG_N-1:0] base_q, base_d;   // g * 2 * half, accumulated per group
  logic [LOG_N-1:0] half_q, half_d;
  logic [LOG_N-1:0] grp_q, grp_d;     // number of groups in the current stage
  logic [LOG_N-1:0] tw_q, tw_d;
  logic [LOG_N-1:0] stage_q, stage_d;
  logic             inv_q, inv_d;

  logic last_j, last_g;

  assign last_j = (j_q == half_q - OneL);
  assign last_g = (g_q == grp_q - OneL);

  always_comb begin
    j_d     = j_q;
    g_d     = g_q;
    base_d  = base_q;
    half_d  = half_q;
    grp_d   = grp_q;
    tw_d    = tw_q;
    stage_d = stage_q;
    inv_d   = inv_q;

    if (clear_i) begin
      j_d     = '0;
      g_d     = '0;
      base_d  = '0;
      stage_d = '0;
      inv_d   = inv_i;
      if (inv_i) begin
        half_d = OneL;
        grp_d  = HalfN;
        tw_d   = AllOnes;
      end else begin
        half_d = HalfN;
        grp_d  = OneL;
        tw_d   = OneL;
      end
    end else if (advance_i) begin
      if (!last_j) begin
        j_d = j_q + OneL;
      end else if (!last_g) begin
        j_d    = '0;
        g_d    = g_q + OneL;
        base_d = base_q + (half_q << 1);
        tw_d   = inv_q ? tw_q - OneL : tw_q + OneL;
      end else if (stage_q == LastStage) begin
        // Transform finished: return to the all-zero idle state.
        j_d     = '0;
        g_d     = '0;
        base_d  = '0;
        half_d  = '0;
        grp_d   = '0;
        tw_d    = '0;
        stage_d = '0;
      end else begin
        j_d     = '0;
        g_d     = '0;
        base_d  = '0;
        stage_d = stage_q + OneL;
        if (inv_q) begin
          half_d = half_q << 1;
          grp_d  = grp_q >> 1;
          // (N >> (s+1)) - 1 equals the old group count minus one
          tw_d   = grp_q - OneL;
        end else begin
          half_d = half_q >> 1;
          grp_d  = grp_q << 1;
          // 1 << (s+1) equals the new group count
          tw_d   = grp_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      j_q     <= '0;
      g_q     <= '0;
      base_q  <= '0;
      half_q  <= '0;
      grp_q   <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      j_q     <= j_d;
      g_q     <= g_d;
      base_q  <= base_d;
      half_q  <= half_d;
      grp_q   <= grp_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
    end
  end

  assign addr_a_o        = base_q + j_q;
  assign addr_b_o        = base_q + j_q + half_q;
  assign tw_idx_o        = tw_q;
  assign stage_o         = stage_q;
  assign last_in_stage_o = (half_q != '0) && last_j && last_g;
  assign last_stage_o    = (stage_q == LastStage);

endmodule

// File: rtl/ntt_stage_ctrl.sv
// NTT stage controller: walks the butterfly unit through all LOG_N stages of an
// N-point in-place transform, one command per accepted handshake, with a
// PIPE_LAT-cycle drain gap after each stage.
// Optional feature macro: NTT_INVERSE_EN adds input inv (Gentleman-Sande ordering).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               transform request, sampled only in IDLE
//   inv                 (NTT_INVERSE_EN only) ordering select, sampled with start
//   busy, done          transform in progress / single-cycle completion pulse
//   bf_valid, bf_ready  butterfly command handshake
//   addr_a, addr_b      coefficient address pair
//   tw_idx              twiddle ROM index
//   stage               current stage number
//   last_in_stage       final butterfly of the current stage
module ntt_stage_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned N        = NttN,
  parameter int unsigned LOG_N    = NttLogN,
  parameter int unsigned PIPE_LAT = NttPipeLat
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef NTT_INVERSE_EN
  input  logic             inv,
`endif
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-1:0] tw_idx,
  output logic [LOG_N-1:0] stage,
  output logic             last_in_stage
);

  localparam int unsigned          DrainW    = (PIPE_LAT > 1) ? ntt_clog2(PIPE_LAT) : 1;
  localparam logic [DrainW-1:0]    DrainLast = DrainW'(PIPE_LAT - 1);

  ntt_state_e        state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              final_q, final_d;   // the stage being drained was the last one

  logic inv_sel;
  logic addr_clear;
  logic xfer;
  logic lis_raw;
  logic last_stage;

`ifdef NTT_INVERSE_EN
  assign inv_sel = inv;
`else
  assign inv_sel = 1'b0;
`endif

  assign bf_valid      = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign xfer          = bf_valid && bf_ready;
  assign last_in_stage = bf_valid && lis_raw;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    final_d    = final_q;
    addr_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_clear = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer && lis_raw) begin
          final_d = last_stage;
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DrainLast) begin
          state_d = final_q ? DONE : ISSUE;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      DONE: begin
        final_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      final_q <= final_d;
    end
  end

  ntt_addr_gen #(
    .N     (N),
    .LOG_N (LOG_N)
  ) u_addr_gen (
    .clk_i           (clk),
    .rst_ni          (rst),
    .clear_i         (addr_clear),
    .advance_i       (xfer),
    .inv_i           (inv_sel),
    .addr_a_o        (addr_a),
    .addr_b_o        (addr_b),
    .tw_idx_o        (tw_idx),
    .stage_o         (stage),
    .last_in_stage_o (lis_raw),
    .last_stage_o    (last_stage)
  );

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
module tb_ntt_stage_ctrl;

  localparam int TN = 8;
  localparam int TL = 3;
  localparam int TP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          bf_ready = 1'b1;
`ifdef NTT_INVERSE_EN
  logic          inv = 1'b0;
`endif
  logic          busy, done, bf_valid, last_in_stage;
  logic [TL-1:0] addr_a, addr_b, tw_idx, stage;

  ntt_stage_ctrl #(
    .N        (TN),
    .LOG_N    (TL),
    .PIPE_LAT (TP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
`ifdef NTT_INVERSE_EN
    .inv           (inv),
`endif
    .busy          (busy),
    .done          (done),
    .bf_valid      (bf_valid),
    .bf_ready      (bf_ready),
    .addr_a        (addr_a),
    .addr_b        (addr_b),
    .tw_idx        (tw_idx),
    .stage         (stage),
    .last_in_stage (last_in_stage)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int done_cnt = 0;
  int last_cnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
    logic [2:0] st;
    logic       last;
  } cmd_t;

  typedef struct {
    int         cyc;
    logic       valid;
    logic       busy;
    logic       done;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
    logic [2:0] st;
    logic       last;
  } vec_t;

  cmd_t sb_q[$];
  cmd_t sb_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ordering built directly from the closed-form address formulas.
  task automatic push_model(input bit inv_v);
    int half, ng, a, tw;
    cmd_t c;
    for (int s = 0; s < TL; s++) begin
      half = inv_v ? (1 << s) : (TN >> (s + 1));
      ng   = inv_v ? (TN >> (s + 1)) : (1 << s);
      for (int g = 0; g < ng; g++) begin
        tw = inv_v ? ((TN >> s) - 1 - g) : ((1 << s) + g);
        for (int j = 0; j < half; j++) begin
          a      = g * 2 * half + j;
          c.a    = 3'(a);
          c.b    = 3'(a + half);
          c.tw   = 3'(tw);
          c.st   = 3'(s);
          c.last = (g == ng - 1) && (j == half - 1);
          sb_q.push_back(c);
        end
      end
    end
  endtask

  // Scoreboard: every transfer pops and compares the next expected command.
  always @(negedge clk) begin
    if (rst && bf_valid && bf_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got transfer a=%0d b=%0d required none", addr_a, addr_b);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_addr_a", 32'(addr_a), 32'(sb_e.a));
        chk("sb_addr_b", 32'(addr_b), 32'(sb_e.b));
        chk("sb_tw_idx", 32'(tw_idx), 32'(sb_e.tw));
        chk("sb_stage", 32'(stage), 32'(sb_e.st));
        chk("sb_last", 32'(last_in_stage), 32'(sb_e.last));
      end
      if (last_in_stage) last_cnt++;
    end
    if (rst && done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int dc);
    bit got = 0;
    dc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        dc  = cycle;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: got no done within 200 cycles, required a done pulse");
    end
  endtask

  task automatic check_after_done(input string nm);
    step();
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(busy), 0);
    chk({nm, "_done_after"}, 32'(done), 0);
    chk({nm, "_sb_drained"}, sb_q.size(), 0);
  endtask

  function automatic vec_t mk(input int c, input bit v, input bit bu, input bit d, input int a,
                              input int b, input int tw, input int st, input bit l);
    vec_t r;
    r.cyc = c; r.valid = v; r.busy = bu; r.done = d;
    r.a = 3'(a); r.b = 3'(b); r.tw = 3'(tw); r.st = 3'(st); r.last = l;
    return r;
  endfunction

  vec_t vecs[16];

  initial begin
    int s0, dc, d0;

    //              cyc v  bu d  a  b  tw st last
    vecs[0]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1,  1, 1, 0, 0, 4, 1, 0, 0);
    vecs[2]  = mk(2,  1, 1, 0, 1, 5, 1, 0, 0);
    vecs[3]  = mk(4,  1, 1, 0, 3, 7, 1, 0, 1);
    vecs[4]  = mk(5,  0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(6,  0, 1, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(7,  1, 1, 0, 0, 2, 2, 1, 0);
    vecs[7]  = mk(8,  1, 1, 0, 1, 3, 2, 1, 0);
    vecs[8]  = mk(9,  1, 1, 0, 4, 6, 3, 1, 0);
    vecs[9]  = mk(10, 1, 1, 0, 5, 7, 3, 1, 1);
    vecs[10] = mk(11, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(13, 1, 1, 0, 0, 1, 4, 2, 0);
    vecs[12] = mk(16, 1, 1, 0, 6, 7, 7, 2, 1);
    vecs[13] = mk(18, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(19, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(20, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(bf_valid), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
    chk("rst_tw", 32'(tw_idx), 0);
    chk("rst_stage", 32'(stage), 0);
    chk("rst_last", 32'(last_in_stage), 0);
    step();
    rst = 1'b1;
    step();

    // Forward transform, no stalls, table-driven cycle checks
    push_model(1'b0);
    last_cnt = 0;
    d0 = done_cnt;
    start = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        if (vecs[k].cyc == c) begin
          chk($sformatf("tbl%0d_valid", c), 32'(bf_valid), 32'(vecs[k].valid));
          chk($sformatf("tbl%0d_busy", c), 32'(busy), 32'(vecs[k].busy));
          chk($sformatf("tbl%0d_done", c), 32'(done), 32'(vecs[k].done));
          chk($sformatf("tbl%0d_last", c), 32'(last_in_stage), 32'(vecs[k].last));
          if (vecs[k].valid) begin
            chk($sformatf("tbl%0d_addr_a", c), 32'(addr_a), 32'(vecs[k].a));
            chk($sformatf("tbl%0d_addr_b", c), 32'(addr_b), 32'(vecs[k].b));
            chk($sformatf("tbl%0d_tw", c), 32'(tw_idx), 32'(vecs[k].tw));
            chk($sformatf("tbl%0d_stage", c), 32'(stage), 32'(vecs[k].st));
          end
        end
      end
      step();
      start = 1'b0;
    end
    chk("fwd_done_count", done_cnt - d0, 1);
    chk("fwd_last_count", last_cnt, 3);
    chk("fwd_sb_drained", sb_q.size(), 0);
    repeat (2) step();

    // Stall: hold bf_ready low for 3 cycles while (1,5) is presented
    push_model(1'b0);
    d0 = done_cnt;
    start = 1'b1;
    s0 = cycle;
    step();
    start = 1'b0;
    step();
    bf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bf_valid), 1);
      chk("stall_addr_a", 32'(addr_a), 1);
      chk("stall_addr_b", 32'(addr_b), 5);
      chk("stall_tw", 32'(tw_idx), 1);
      chk("stall_stage", 32'(stage), 0);
      chk("stall_last", 32'(last_in_stage), 0);
      step();
    end
    bf_ready = 1'b1;
    wait_done(dc);
    chk("stall_done_latency", dc - s0, 22);
    check_after_done("stall");
    chk("stall_done_count", done_cnt - d0, 1);
    repeat (2) step();

    // start pulsed in ISSUE and in the DONE cycle must be ignored
    push_model(1'b0);
    d0 = done_cnt;
    for (int c = 0; c <= 22; c++) begin
      start = (c == 0 || c == 3 || c == 19);
      @(negedge clk);
      if (c == 19) chk("pulse_done_t19", 32'(done), 1);
      if (c >= 20) chk($sformatf("pulse_busy_t%0d", c), 32'(busy), 0);
      step();
    end
    start = 1'b0;
    chk("pulse_done_count", done_cnt - d0, 1);
    chk("pulse_sb_drained", sb_q.size(), 0);

    // Asynchronous reset during stage 1 aborts without done
    push_model(1'b0);
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    @(negedge clk);
    chk("abort_pre_stage", 32'(stage), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(bf_valid), 0);
    chk("abort_addr_a", 32'(addr_a), 0);
    chk("abort_addr_b", 32'(addr_b), 0);
    chk("abort_tw", 32'(tw_idx), 0);
    chk("abort_stage", 32'(stage), 0);
    chk("abort_last", 32'(last_in_stage), 0);
    sb_q.delete();
    repeat (2) step();
    rst = 1'b1;
    repeat (25) step();
    chk("abort_no_done", done_cnt - d0, 0);
    push_model(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("restart_addr_a", 32'(addr_a), 0);
    chk("restart_addr_b", 32'(addr_b), 4);
    chk("restart_stage", 32'(stage), 0);
    wait_done(dc);
    check_after_done("restart");
    chk("restart_done_count", done_cnt - d0, 1);

`ifdef NTT_INVERSE_EN
    // Gentleman-Sande ordering; inv dropped after start to show it was sampled
    push_model(1'b1);
    last_cnt = 0;
    d0 = done_cnt;
    inv = 1'b1;
    start = 1'b1;
    s0 = cycle;
    step();
    start = 1'b0;
    inv = 1'b0;
    wait_done(dc);
    chk("inv_done_latency", dc - s0, 19);
    check_after_done("inv");
    chk("inv_last_count", last_cnt, 3);
    chk("inv_done_count", done_cnt - d0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequences the butterfly unit of the NTT accelerator through all LOG_N stages of an N-point in-place transform.
- Issues one butterfly per accepted handshake: coefficient address pair plus twiddle index.
- Inserts a drain gap between stages so the registered butterfly pipeline retires before the next stage reads.
- Sits between the top-level command interface (start/done) and the coefficient RAM / butterfly datapath.

Parameters:
- N, 256, transform length; power of two, N >= 4.
- LOG_N, 8, log2(N); also the width of all address and twiddle fields.
- PIPE_LAT, 4, butterfly pipeline depth in cycles; gap cycles inserted after each stage; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  transform request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when the transform completes.
- bf_valid  out  1  butterfly command valid.
- bf_ready  in  1  datapath accepts the command.
- addr_a  out  LOG_N  upper-leg coefficient address.
- addr_b  out  LOG_N  lower-leg coefficient address, = addr_a + half.
- tw_idx  out  LOG_N  twiddle ROM index.
- stage  out  LOG_N  current stage number, 0..LOG_N-1.
- last_in_stage  out  1  high with the final butterfly of the stage.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; all counters 0. Reset mid-transform aborts immediately with no done pulse.
- States and transitions:
  - IDLE: start=1 -> ISSUE.
  - ISSUE: last butterfly accepted -> DRAIN.
  - DRAIN: after PIPE_LAT cycles -> ISSUE (next stage) or DONE (after stage LOG_N-1).
  - DONE: -> IDLE after one cycle.
- Forward ordering, stage s:
  - half = N>>(s+1); groups g = 0..(1<<s)-1; j = 0..half-1, with j incrementing fastest.
  - addr_a = g*2*half + j; addr_b = addr_a + half; tw_idx = (1<<s) + g.
- Timing: start accepted at cycle t -> bf_valid=1 at t+1 with the first command.
- Handshake:
  - A command is transferred when bf_valid && bf_ready.
  - Counters advance only on transfer.
  - While bf_ready=0, bf_valid, addr_a, addr_b, tw_idx, stage and last_in_stage hold stable.
- DRAIN: bf_valid=0 for exactly PIPE_LAT cycles; the count starts in the cycle after the last transfer; bf_ready is ignored.
- DONE: done=1 and busy=1 for that one cycle; busy=0 in the following IDLE cycle.
- start while not IDLE, including the DONE cycle: ignored, no queuing.
- Unstalled latency from start to done: 1 + LOG_N*(N/2 + PIPE_LAT) cycles (done asserted at t+1+LOG_N*(N/2+PIPE_LAT)).
- No multipliers: the base address is accumulated by adding 2*half per group. All arithmetic is LOG_N-bit and never overflows.

Optional Feature:
- Macro: NTT_INVERSE_EN.
- With the macro defined:
  - Adds input port inv (1 bit), sampled when start is accepted and held for the whole transform.
  - inv=1 selects Gentleman-Sande ordering: stage s has half = 1<<s and groups g = 0..(N>>(s+1))-1.
  - Address formulas are the same as forward; tw_idx = (N>>s) - 1 - g.
  - inv=0 gives forward ordering.
- Without the macro: no inv port; forward ordering only.

Decomposition:
- Package ntt_ctrl_pkg holds:
  - state encoding constants IDLE/ISSUE/DRAIN/DONE (2 bits);
  - the clog2 helper function;
  - the default N/LOG_N/PIPE_LAT values shared with the datapath.
- One sub-module, ntt_addr_gen: nested j/g/stage counters producing addr_a, addr_b, tw_idx and last_in_stage from an advance strobe.
- FSM and drain counter stay in ntt_stage_ctrl.

Test Plan (N=8, LOG_N=3, PIPE_LAT=2):
- Forward, bf_ready=1, start at t0:
  - stage 0, t1..t4: pairs (0,4),(1,5),(2,6),(3,7), tw 1.
  - t5..t6: bf_valid=0.
  - stage 1: pairs (0,2),(1,3) tw 2; (4,6),(5,7) tw 3.
  - stage 2: pairs (0,1),(2,3),(4,5),(6,7) with tw 4,5,6,7.
  - done=1 at t19 only.
- Stall: bf_ready=0 for 3 cycles while (1,5) is presented -> (1,5), tw 1 held stable all 3 cycles; next transfer gives (2,6); done delayed by exactly 3 cycles.
- start pulsed during ISSUE and during the DONE cycle -> ignored; exactly one done; busy=0 the cycle after done.
- rst=0 asserted during stage 1 -> all outputs 0 immediately; no done; a fresh start afterwards begins again at (0,4), stage 0.
- NTT_INVERSE_EN, inv=1:
  - stage 0: (0,1) tw 7, (2,3) tw 6, (4,5) tw 5, (6,7) tw 4.
  - stage 1: (0,2),(1,3) tw 3; (4,6),(5,7) tw 2.
  - stage 2: (0,4)..(3,7) tw 1.
- last_in_stage: high only on the 4th transfer of each stage; asserts 3 times per transform.
